// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
//   Shared widths and small helpers for the operand-fetch stage and its
//   register scoreboard.
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // Wide enough to hold 0..31 busy registers.
  localparam int CNT_W      = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;
  typedef logic [NUM_REGS-1:0]   busy_vec_t;

  // A same-cycle writeback to this nonzero address can be forwarded.
  function automatic logic wb_forwards(input logic      wb_valid,
                                       input reg_addr_t wb_rd,
                                       input reg_addr_t addr);
    return wb_valid && (addr != '0) && (wb_rd == addr);
  endfunction

  // The register still has an outstanding write that is not being
  // resolved by this cycle's writeback.
  function automatic logic still_pending(input busy_vec_t busy,
                                         input reg_addr_t addr,
                                         input logic      wb_valid,
                                         input reg_addr_t wb_rd);
    return (addr != '0) && busy[addr] && !wb_forwards(wb_valid, wb_rd, addr);
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// -----------------------------------------------------------------------------
// op_scoreboard
//   Pending-write scoreboard: one busy bit per architectural register
//   (x0 never busy), a registered population count and a sticky error flag
//   for writebacks that target a register with no pending write.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   i_set_en/addr    issue of an instruction that writes i_set_addr
//   i_clr_en/addr    writeback to i_clr_addr
//   o_busy           busy vector, bit 0 tied low
//   o_inflight       number of busy registers
//   o_wb_err         sticky: writeback to a nonzero, non-busy register
// -----------------------------------------------------------------------------
module op_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_set_en,
  input  reg_addr_t        i_set_addr,
  input  logic             i_clr_en,
  input  reg_addr_t        i_clr_addr,
  output busy_vec_t        o_busy,
  output logic [CNT_W-1:0] o_inflight,
  output logic             o_wb_err
);

  logic [NUM_REGS-1:1] r_busy;
  logic [CNT_W-1:0]    r_inflight;
  logic                r_wb_err;

  busy_vec_t w_busy;
  busy_vec_t w_busy_nxt;
  logic      w_set;
  logic      w_clr_req;
  logic      w_clr_hit;
  logic      w_same_reg;
  logic      w_inc;
  logic      w_dec;

  assign w_busy     = {r_busy, 1'b0};
  assign w_set      = i_set_en && (i_set_addr != '0);
  assign w_clr_req  = i_clr_en && (i_clr_addr != '0);
  // A writeback to a non-busy register leaves the scoreboard untouched.
  assign w_clr_hit  = w_clr_req && w_busy[i_clr_addr];
  assign w_same_reg = w_set && (i_set_addr == i_clr_addr);

  // The count tracks real bit transitions so it always equals the
  // population of the busy vector: a set on an already-busy register
  // (only legal when the same register is cleared this cycle) adds nothing,
  // and a clear overridden by a set on the same register removes nothing.
  assign w_inc = w_set && !w_busy[i_set_addr];
  assign w_dec = w_clr_hit && !w_same_reg;

  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can leave a latch behind.
    w_busy_nxt = w_busy;
    if (w_clr_hit) w_busy_nxt[i_clr_addr] = 1'b0;
    // Set is applied last so it wins over a clear of the same register.
    if (w_set)     w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= '0;
      r_inflight <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt[NUM_REGS-1:1];
      unique case ({w_inc, w_dec})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_clr_req && !w_busy[i_clr_addr]) r_wb_err <= 1'b1;
    end
  end

  assign o_busy     = w_busy;
  assign o_inflight = r_inflight;
  assign o_wb_err   = r_wb_err;

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Operand-fetch stage: checks RAW/WAW hazards against a pending-write
//   scoreboard, reads the register file (with same-cycle writeback bypass)
//   and hands a registered operand bundle to execute under valid/ready.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid / in_ready           decoded-instruction handshake
//   in_rs1/rs2, in_use_rs1/rs2    source addresses and use flags
//   in_rd, in_rd_we               destination and its write enable
//   rf_rs1/rs2, rf_readdata1/2    combinational register-file read port
//   wb_valid, wb_rd, wb_data      writeback bus
//   out_valid / out_ready         bundle handshake towards execute
//   out_op1/op2, out_rd/rd_we     registered bundle
//   inflight                      number of registers with a pending write
//   wb_err                        sticky writeback-to-idle-register flag
// -----------------------------------------------------------------------------
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  reg_addr_t        in_rs1,
  input  reg_addr_t        in_rs2,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  reg_addr_t        in_rd,
  input  logic             in_rd_we,
  output reg_addr_t        rf_rs1,
  output reg_addr_t        rf_rs2,
  input  xdata_t           rf_readdata1,
  input  xdata_t           rf_readdata2,
  input  logic             wb_valid,
  input  reg_addr_t        wb_rd,
  input  xdata_t           wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output xdata_t           out_op1,
  output xdata_t           out_op2,
  output reg_addr_t        out_rd,
  output logic             out_rd_we,
  output logic [CNT_W-1:0] inflight,
  output logic             wb_err
);

  logic      r_out_valid;
  xdata_t    r_out_op1;
  xdata_t    r_out_op2;
  reg_addr_t r_out_rd;
  logic      r_out_rd_we;

  busy_vec_t w_busy;
  logic      w_raw_hazard;
  logic      w_waw_hazard;
  logic      w_slot_free;
  logic      w_accept;
  xdata_t    w_op1;
  xdata_t    w_op2;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  // Unused sources never stall; a pending write being written back this
  // cycle is resolved by the bypass, so it does not stall either.
  assign w_raw_hazard = (in_use_rs1 && still_pending(w_busy, in_rs1, wb_valid, wb_rd))
                     || (in_use_rs2 && still_pending(w_busy, in_rs2, wb_valid, wb_rd));
  assign w_waw_hazard = in_rd_we && still_pending(w_busy, in_rd, wb_valid, wb_rd);

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = w_slot_free && !w_raw_hazard && !w_waw_hazard;
  assign w_accept    = in_valid && in_ready;

  assign w_op1 = wb_forwards(wb_valid, wb_rd, in_rs1) ? wb_data : rf_readdata1;
  assign w_op2 = wb_forwards(wb_valid, wb_rd, in_rs2) ? wb_data : rf_readdata2;

  op_scoreboard u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_set_en   (w_accept && in_rd_we),
    .i_set_addr (in_rd),
    .i_clr_en   (wb_valid),
    .i_clr_addr (wb_rd),
    .o_busy     (w_busy),
    .o_inflight (inflight),
    .o_wb_err   (wb_err)
  );

  // Bundle data only loads on accept, so it holds while execute stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_op1   <= '0;
      r_out_op2   <= '0;
      r_out_rd    <= '0;
      r_out_rd_we <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_op1   <= w_op1;
      r_out_op2   <= w_op2;
      r_out_rd    <= in_rd;
      r_out_rd_we <= in_rd_we;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_op1   = r_out_op1;
  assign out_op2   = r_out_op2;
  assign out_rd    = r_out_rd;
  assign out_rd_we = r_out_rd_we;

endmodule
